// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS Moore control FSM with mem_ready stalls.
// Define MC_ADDI_EN to compile in the addi path (I_EXEC/I_WB); otherwise addi decodes as illegal.
module mips_mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
`ifdef MC_ADDI_EN
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
`endif
        JUMP      = 4'd9
    } state_t;

    state_t     r_state, w_next;
    logic [5:0] r_opcode;
    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
    logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_instr_done, w_illegal_op;
    logic [1:0] w_alu_src_b, w_pc_source, w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next          = FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_op        = 2'b00;
        w_instr_done    = 1'b0;
        w_illegal_op    = 1'b0;
        case (r_state)
            FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                w_next      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut captures PC + (imm << 2) so BRANCH can use it as target
                w_alu_src_b = 2'b11;
                if (opcode == OP_R) w_next = R_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW) w_next = MEM_ADDR;
                else if (opcode == OP_BEQ) w_next = BRANCH;
                else if (opcode == OP_J) w_next = JUMP;
`ifdef MC_ADDI_EN
                else if (opcode == OP_ADDI) w_next = I_EXEC;
`endif
                else w_illegal_op = 1'b1;
            end
            MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (r_opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            MEM_WRITE: begin
                w_mem_write  = 1'b1;
                w_i_or_d     = 1'b1;
                w_instr_done = mem_ready;
                w_next       = mem_ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = R_WB;
            end
            R_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
            end
            JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = I_WB;
            end
            I_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
`endif
            default: w_next = FETCH;
        endcase
    end

    // FETCH decodes to nonzero outputs, so everything is forced low while reset is held
    assign {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal_op} =
           {18{rst_n}} & {w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write,
            w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_alu_src_b,
            w_pc_source, w_alu_op, w_instr_done, w_illegal_op};
    assign state = rst_n ? r_state : 4'd0;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized check of the multi-cycle control FSM against a per-instruction cycle model.
module tb_mips_mc_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic [3:0] state;
    logic [17:0] w_act;

    int n_cmp = 0;
    int n_err = 0;
    int q_st[$];
    logic q_mr[$];

    mips_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign w_act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal_op};

    function automatic logic addi_en();
`ifdef MC_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic legal(logic [5:0] op);
        return (op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2 ||
                (addi_en() && op == 6'd8));
    endfunction

    // Expected output word for one cycle, straight from the per-state output table
    function automatic logic [17:0] exp_out(int st, logic mr, logic [5:0] op);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
        logic rw = 0, asa = 0, idn = 0, ill = 0;
        logic [1:0] asb = 0, pcs = 0, aop = 0;
        case (st)
            0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            1: begin asb = 2'b11; ill = !legal(op); end
            2: begin asa = 1; asb = 2'b10; end
            3: begin mrd = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; idn = 1; end
            5: begin mwr = 1; iod = 1; idn = mr; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rw = 1; rdst = 1; idn = 1; end
            8: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; idn = 1; end
            9: begin pw = 1; pcs = 2'b10; idn = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; idn = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, idn, ill};
    endfunction

    task automatic push(int st, logic mr);
        q_st.push_back(st);
        q_mr.push_back(mr);
    endtask

    task automatic push_wait(int st, int stalls);
        for (int i = 0; i < stalls; i++) push(st, 1'b0);
        push(st, 1'b1);
    endtask

    // Cycle-by-cycle state trace of one instruction from the latency/stall rules
    task automatic build(logic [5:0] op, int fs, int ms);
        q_st.delete();
        q_mr.delete();
        push_wait(0, fs);
        push(1, 1'($urandom));
        if (!legal(op)) return;
        case (op)
            6'd0:  begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            6'd35: begin push(2, 1'($urandom)); push_wait(3, ms); push(4, 1'($urandom)); end
            6'd43: begin push(2, 1'($urandom)); push_wait(5, ms); end
            6'd4:  push(8, 1'($urandom));
            6'd2:  push(9, 1'($urandom));
            default: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
        endcase
    endtask

    task automatic run_instr(string name, logic [5:0] op, int fs, int ms);
        build(op, fs, ms);
        foreach (q_st[i]) begin
            @(negedge clk);
            mem_ready = q_mr[i];
            opcode = (q_st[i] == 1) ? op : 6'($urandom);
            #1;
            n_cmp++;
            if (state !== 4'(q_st[i])) begin
                n_err++;
                $display("FAIL %s op=%b cyc %0d state: got %0d want %0d", name, op, i, state, q_st[i]);
            end
            n_cmp++;
            if (w_act !== exp_out(q_st[i], q_mr[i], op)) begin
                n_err++;
                $display("FAIL %s op=%b cyc %0d outputs: got %b want %b", name, op, i, w_act,
                         exp_out(q_st[i], q_mr[i], op));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'd0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({state, w_act} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_hold: got state=%0d out=%b want all 0", state, w_act);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (w_act !== exp_out(0, 1'b1, 6'd0) || state !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release: got state=%0d out=%b want state=0 out=%b", state, w_act,
                     exp_out(0, 1'b1, 6'd0));
        end
        run_instr("reset_first_instr", 6'b000000, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr("lw_stall", 6'b100011, 0, 2);
        run_instr("lw_nostall", 6'b100011, 1, 0);
        run_instr("sw_stall", 6'b101011, 2, 3);
    endtask

    task automatic test_rtype();
        run_instr("rtype", 6'b000000, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr("beq", 6'b000100, 0, 0);
        run_instr("j", 6'b000010, 1, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'b111111, 0, 0);
        run_instr("addi_or_illegal", 6'b001000, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); mem_ready = 1'b1; opcode = 6'($urandom);
        @(negedge clk); opcode = 6'b101011;
        @(negedge clk); opcode = 6'($urandom);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: got state=%0d mem_write=%b want 5/1", state, mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, w_act} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_mid_abort: got state=%0d out=%b want all 0", state, w_act);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_release: got state=%0d want 0", state);
        end
        run_instr("after_reset_mid", 6'b000100, 1, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd0};
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op = ops[$urandom_range(0, 6)];
            if (i % 7 == 6) op = 6'($urandom);
            run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_rtype();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control unit for the 32-bit MIPS processor. A Moore state machine decodes the 6-bit opcode latched in the instruction register and drives every datapath select and write enable for one instruction at a time. Its outputs feed the 2:1 datapath muxes, the ALU operand-B 4:1 mux, the PC-source 4:1 mux, the ALU control decoder, the register file, the IR, the PC and the memory port. Memory accesses stall on a `mem_ready` handshake.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]. Sampled in DECODE only.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero flag is set.
- `i_or_d` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` output 1 each: memory strobes.
- `ir_write` output 1: IR load.
- `mem_to_reg` output 1: write-data select. 0 = ALUOut, 1 = MDR.
- `reg_dst` output 1: destination select. 0 = rt, 1 = rd.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: operand A select. 0 = PC, 1 = regA.
- `alu_src_b` output 2: operand B select. 00 = regB, 01 = const 4, 10 = ImmExt, 11 = ImmExt<<2.
- `pc_source` output 2: PC source select. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `state` output 4: current state code, for debug.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` output 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11. Codes 12–15 are unused; the FSM goes from any of them to FETCH on the next edge.

Outputs that each state asserts (any output not listed is 0):
- **FETCH**: mem_read=1, alu_src_b=01. ir_write and pc_write equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: alu_src_b=11, so ALUOut receives the branch target. Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → I_EXEC
  - anything else → FETCH, with illegal_op=1 in the DECODE cycle.
- **MEM_ADDR**: alu_src_a=1, alu_src_b=10. Next state is MEM_READ for lw, MEM_WRITE for sw. The opcode is held in an internal register latched in DECODE.
- **MEM_READ**: mem_read=1, i_or_d=1. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB**: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- **MEM_WRITE**: mem_write=1, i_or_d=1. Waits for `mem_ready`. instr_done equals `mem_ready`. Goes to FETCH on `mem_ready`.
- **R_EXEC**: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- **R_WB**: reg_write=1, reg_dst=1, instr_done=1. Goes to FETCH.
- **BRANCH**: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- **JUMP**: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- **I_EXEC**: alu_src_a=1, alu_src_b=10. Goes to I_WB.
- **I_WB**: reg_write=1, reg_dst=0, instr_done=1. Goes to FETCH.

## Timing
Reset:
- While `rst_n`=0, `state`=0 (FETCH) and every other output is 0.
- All outputs are combinational decodes of the state register, gated by `rst_n`.
- Asserting reset mid-instruction, including during a wait on `mem_ready`, aborts the instruction immediately. No write enable stays asserted.
- After release, the first edge with `mem_ready`=1 completes the fetch.

Instruction latency in cycles, with `mem_ready` held at 1:

| Instruction | Cycles |
|---|---|
| R-type | 4 |
| lw | 5 |
| sw | 4 |
| beq | 3 |
| j | 3 |
| addi | 4 |

Stalls and sampling:
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- `mem_ready` is ignored in every other state.
- `opcode` is sampled only on the DECODE edge; changes elsewhere have no effect.
- instr_done and illegal_op are never high in the same cycle.

## Configuration
- `MC_ADDI_EN`
  - Defined: the addi path (I_EXEC, I_WB) is compiled in.
  - Undefined: those states do not exist. Opcode 001000 is handled as illegal: DECODE → FETCH with illegal_op=1.

## Test plan
- **Reset then fetch.** Hold `rst_n`=0, then release with `mem_ready`=1.
  - While in reset: all outputs 0.
  - First cycle after release: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- **lw with stall.** opcode=100011, `mem_ready` low for 2 cycles in MEM_READ.
  - States: 0,1,2,3,3,3,4,0.
  - instr_done high only in state 4, together with reg_write=1 and mem_to_reg=1.
- **R-type.** opcode=000000.
  - States: 0,1,6,7,0.
  - State 6: alu_op=10.
  - State 7: reg_dst=1, reg_write=1.
- **beq and j.** opcodes 000100 and 000010.
  - beq: BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01.
  - j: JUMP drives pc_write=1, pc_source=10.
- **Illegal opcode.** opcode=111111.
  - illegal_op=1 in DECODE, next state FETCH, no write enable asserted.
  - Repeat with opcode=001000 in a build without `MC_ADDI_EN`: same result.
- **Reset mid-instruction.** Assert `rst_n`=0 while in MEM_WRITE with `mem_ready`=0.
  - mem_write drops immediately.
  - `state`=0 after release.
